// File: rtl/basgate_pkg.sv
// ------------------------------------------------------------------
// basgate_pkg: op codes, op width and FSM encoding for basgate_seq_unit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package basgate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_NAND = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
  localparam logic [OP_W-1:0] OP_NOTB = 3'd7;

  localparam logic [OP_W-1:0] OP_LAST = OP_NOTB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_OUT = 2'd1,
    S_GAP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/basgate_logic_core.sv
// ------------------------------------------------------------------
// basgate_logic_core: combinational W-bit bitwise op selected by op_i
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module basgate_logic_core
  import basgate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  input  logic [OP_W-1:0] op_i,
  output logic [W-1:0]    y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_OR:   y_o = a_i | b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_NOTA: y_o = ~a_i;
      OP_NOTB: y_o = ~b_i;
      default: y_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/basgate_seq_unit.sv
// ------------------------------------------------------------------
// basgate_seq_unit: registered bitwise-op unit, single-result or 8-op sweep
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module basgate_seq_unit
  import basgate_pkg::*;
#(
  parameter int W     = 8,
  parameter int DWELL = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic [OP_W-1:0] OP,
  input  logic            MODE,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [W-1:0]    Y,
  output logic [OP_W-1:0] Y_OP,
  output logic            ZERO,
  output logic            PARITY,
  output logic            BUSY
);

  localparam int DW = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);

  state_e          state_q, state_d;
  logic [OP_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    y_q, y_d;
  logic [OP_W-1:0] yop_q, yop_d;
  logic            zero_q, zero_d, par_q, par_d, valid_q, valid_d;

  logic            w_accept, w_deliver, w_load;
  logic [W-1:0]    w_core_a, w_core_b, w_core_y;
  logic [OP_W-1:0] w_core_op;

  assign IN_READY  = RST_N & (state_q == IDLE) & (~valid_q | OUT_READY);
  assign w_accept  = IN_VALID & IN_READY;
  assign w_deliver = valid_q & OUT_READY;

  // S_OUT only loads on a back-to-back sweep step, so it looks one op ahead.
  always_comb begin
    w_core_a  = a_q;
    w_core_b  = b_q;
    w_core_op = cnt_q;
    case (state_q)
      IDLE: begin
        w_core_a  = A;
        w_core_b  = B;
        w_core_op = MODE ? OP_AND : OP;
      end
      S_OUT:   w_core_op = cnt_q + 3'd1;
      default: w_core_op = cnt_q;
    endcase
  end

  basgate_logic_core #(.W(W)) u_core (
    .a_i  (w_core_a),
    .b_i  (w_core_b),
    .op_i (w_core_op),
    .y_o  (w_core_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    w_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          w_load  = 1'b1;
          valid_d = 1'b1;
          if (MODE) begin
            state_d = S_OUT;
            a_d     = A;
            b_d     = B;
            cnt_d   = OP_AND;
          end
        end else if (w_deliver) begin
          valid_d = 1'b0;
        end
      end
      S_OUT: begin
        if (w_deliver) begin
          if (cnt_q == OP_LAST) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (DWELL > 0) begin
              state_d = S_GAP;
              valid_d = 1'b0;
              dwell_d = DW'(DWELL);
            end else begin
              w_load = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (dwell_q <= DW'(1)) begin
          state_d = S_OUT;
          valid_d = 1'b1;
          w_load  = 1'b1;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    y_d    = y_q;
    yop_d  = yop_q;
    zero_d = zero_q;
    par_d  = par_q;
    if (w_load) begin
      y_d    = w_core_y;
      yop_d  = w_core_op;
      zero_d = (w_core_y == '0);
      par_d  = ^w_core_y;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      yop_q   <= '0;
      zero_q  <= 1'b0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      yop_q   <= yop_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      valid_q <= valid_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign Y         = y_q;
  assign Y_OP      = yop_q;
  assign ZERO      = zero_q;
  assign PARITY    = par_q;
  assign BUSY      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_basgate_seq_unit.sv
// ------------------------------------------------------------------
// tb_basgate_seq_unit: randomized self-checking bench, DWELL=2 and DWELL=0 units
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_basgate_seq_unit;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [2:0] OP = '0;
  logic       MODE = 1'b0;
  logic       OUT_READY = 1'b0;

  logic       ir2, ov2, z2, p2, bz2, ir0, ov0, z0, p0, bz0;
  logic [7:0] y2, y0;
  logic [2:0] yop2, yop0;

  bit         use0 = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       o_ready, o_valid, o_zero, o_par, o_busy;
  logic [7:0] o_y;
  logic [2:0] o_yop;

  assign o_ready = use0 ? ir0  : ir2;
  assign o_valid = use0 ? ov0  : ov2;
  assign o_zero  = use0 ? z0   : z2;
  assign o_par   = use0 ? p0   : p2;
  assign o_busy  = use0 ? bz0  : bz2;
  assign o_y     = use0 ? y0   : y2;
  assign o_yop   = use0 ? yop0 : yop2;

  always #5 CLK = ~CLK;

  basgate_seq_unit #(.W(8), .DWELL(2)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(ir2),
    .A(A), .B(B), .OP(OP), .MODE(MODE), .OUT_VALID(ov2), .OUT_READY(OUT_READY),
    .Y(y2), .Y_OP(yop2), .ZERO(z2), .PARITY(p2), .BUSY(bz2)
  );

  basgate_seq_unit #(.W(8), .DWELL(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(ir0),
    .A(A), .B(B), .OP(OP), .MODE(MODE), .OUT_VALID(ov0), .OUT_READY(OUT_READY),
    .Y(y0), .Y_OP(yop0), .ZERO(z0), .PARITY(p0), .BUSY(bz0)
  );

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return ~b;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; MODE = 1'b0;
    step(); step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    step(); step();
    for (int s = 0; s < 2; s++) begin
      use0 = bit'(s);
      #0;
      checks++;
      if (o_valid !== 1'b0 || o_y !== 8'h00 || o_yop !== 3'd0 || o_zero !== 1'b0 ||
          o_par !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b y=%h yop=%0d zero=%b par=%b busy=%b ready=%b, expected all 0",
                 s, o_valid, o_y, o_yop, o_zero, o_par, o_busy, o_ready);
      end
    end
    IN_VALID = 1'b0;
    RST_N = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      use0 = bit'(s);
      #0;
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_release dut%0d: in_ready=%b expected 1", s, o_ready);
      end
    end
    use0 = 1'b0;
  endtask

  task automatic test_single_ops();
    logic [7:0] tab [8];
    tab = '{8'h81, 8'h7E, 8'hE7, 8'h18, 8'h66, 8'h99, 8'h3C, 8'h5A};
    A = 8'hC3; B = 8'hA5; MODE = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b1;
    for (int k = 0; k < 8; k++) begin
      OP = 3'(k);
      step();
      checks++;
      if (o_valid !== 1'b1 || o_y !== tab[k] || o_yop !== 3'(k)) begin
        errors++;
        $display("FAIL single_op%0d: valid=%b y=%h yop=%0d, expected valid=1 y=%h yop=%0d",
                 k, o_valid, o_y, o_yop, tab[k], k);
      end
    end
    IN_VALID = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    A = 8'hC3; B = 8'hA5; OP = 3'd2; MODE = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b0;
    step();
    OP = 3'd0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_valid !== 1'b1 || o_y !== 8'hE7 || o_yop !== 3'd2 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold c%0d: valid=%b y=%h yop=%0d ready=%b, expected 1 e7 2 0",
                 c, o_valid, o_y, o_yop, o_ready);
      end
      step();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    #0;
    checks++;
    if (o_valid !== 1'b1 || o_y !== 8'hE7) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b y=%h expected 1 e7", o_valid, o_y);
    end
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_flags();
    logic [7:0] fa [2], fb [2], fy [2];
    logic [2:0] fo [2];
    logic       fz [2], fp [2];
    fa = '{8'hFF, 8'h07}; fb = '{8'hFF, 8'h00}; fo = '{3'd4, 3'd2};
    fy = '{8'h00, 8'h07}; fz = '{1'b1, 1'b0};   fp = '{1'b0, 1'b1};
    OUT_READY = 1'b1; MODE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      A = fa[i]; B = fb[i]; OP = fo[i]; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_y !== fy[i] || o_zero !== fz[i] || o_par !== fp[i]) begin
        errors++;
        $display("FAIL flags%0d: valid=%b y=%h zero=%b par=%b, expected 1 %h %b %b",
                 i, o_valid, o_y, o_zero, o_par, fy[i], fz[i], fp[i]);
      end
      step();
    end
  endtask

  task automatic test_random_single(input int sel);
    bit         ev;
    logic [7:0] ey;
    logic [2:0] eop;
    bit         er, acc;
    use0 = bit'(sel);
    do_reset();
    ev = 1'b0; ey = '0; eop = '0;
    MODE = 1'b0;
    for (int c = 0; c < 80; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      A = 8'($urandom); B = 8'($urandom); OP = 3'($urandom);
      #0;
      er = !ev || OUT_READY;
      checks++;
      if (o_ready !== er || o_valid !== ev) begin
        errors++;
        $display("FAIL rand_hs dut%0d c%0d: ready=%b valid=%b, expected %b %b", sel, c, o_ready, o_valid, er, ev);
      end
      if (ev) begin
        checks++;
        if (o_y !== ey || o_yop !== eop || o_zero !== (ey == 8'h00) || o_par !== ^ey) begin
          errors++;
          $display("FAIL rand_data dut%0d c%0d: y=%h yop=%0d zero=%b par=%b, expected %h %0d %b %b",
                   sel, c, o_y, o_yop, o_zero, o_par, ey, eop, (ey == 8'h00), ^ey);
        end
      end
      acc = IN_VALID && er;
      if (acc) begin
        ev = 1'b1; ey = ref_op(A, B, OP); eop = OP;
      end else if (ev && OUT_READY) begin
        ev = 1'b0;
      end
      step();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    step();
  endtask

  task automatic run_sweep(input logic [7:0] a, input logic [7:0] b, input int dwell,
                           input bit stall_en, input int stop_after);
    int         k, g, cyc;
    logic [7:0] ey;
    bit         rdy;
    A = a; B = b; MODE = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #0;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL sweep_accept: in_ready=%b expected 1", o_ready);
    end
    step();
    k = 0; g = 0; cyc = 0;
    while (k < stop_after && cyc < 200) begin
      IN_VALID = ($urandom_range(0, 1) != 0);
      MODE = ($urandom_range(0, 1) != 0);
      OP = 3'($urandom); A = 8'($urandom); B = 8'($urandom);
      rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      OUT_READY = rdy;
      #0;
      checks++;
      if (o_busy !== 1'b1 || o_ready !== 1'b0 || o_valid !== (g == 0)) begin
        errors++;
        $display("FAIL sweep_ctrl beat%0d cyc%0d: busy=%b ready=%b valid=%b, expected 1 0 %b",
                 k, cyc, o_busy, o_ready, o_valid, (g == 0));
      end
      if (g == 0) begin
        ey = ref_op(a, b, k[2:0]);
        checks++;
        if (o_y !== ey || o_yop !== k[2:0]) begin
          errors++;
          $display("FAIL sweep_beat%0d: y=%h yop=%0d, expected %h %0d", k, o_y, o_yop, ey, k);
        end
        if (rdy) begin
          k++;
          g = dwell;
        end
      end else begin
        g--;
      end
      step();
      cyc++;
    end
    if (k < stop_after) begin
      errors++;
      $display("FAIL sweep_timeout: beats=%0d expected %0d", k, stop_after);
    end
    if (stop_after == 8) begin
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL sweep_end: valid=%b busy=%b ready=%b, expected 0 0 1", o_valid, o_busy, o_ready);
      end
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1; MODE = 1'b0;
  endtask

  task automatic test_sweep_dwell2();
    use0 = 1'b0;
    do_reset();
    run_sweep(8'hC3, 8'hA5, 2, 1'b0, 8);
    run_sweep(8'hC3, 8'hA5, 2, 1'b1, 8);
    run_sweep(8'($urandom), 8'($urandom), 2, 1'b1, 8);
  endtask

  task automatic test_sweep_dwell0();
    use0 = 1'b1;
    do_reset();
    run_sweep(8'($urandom), 8'($urandom), 0, 1'b0, 8);
    run_sweep(8'($urandom), 8'($urandom), 0, 1'b1, 8);
  endtask

  task automatic test_reset_mid_sweep();
    use0 = 1'b0;
    do_reset();
    run_sweep(8'hC3, 8'hA5, 2, 1'b0, 4);
    RST_N = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_y !== 8'h00 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_reset: valid=%b busy=%b y=%h ready=%b, expected 0 0 00 0",
               o_valid, o_busy, o_y, o_ready);
    end
    RST_N = 1'b1;
    step();
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_release: ready=%b busy=%b, expected 1 0", o_ready, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      use0 = bit'(s);
      do_reset();
      A = 8'h5A; B = 8'h0F; OP = 3'd5; MODE = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
      step();
      checks++;
      if (o_valid !== 1'b1 || o_y !== ref_op(8'h5A, 8'h0F, 3'd5) || o_yop !== 3'd5) begin
        errors++;
        $display("FAIL b2b_single dut%0d: valid=%b y=%h yop=%0d", s, o_valid, o_y, o_yop);
      end
      run_sweep(8'($urandom), 8'($urandom), (s == 1) ? 0 : 2, 1'b1, 8);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_backpressure();
    test_flags();
    test_random_single(0);
    test_random_single(1);
    test_sweep_dwell2();
    test_sweep_dwell0();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
